// File: rtl/beta_flag_pkg.sv
// Shared types and helpers for the Beta add/subtract flag generator.
package beta_flag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } flag_state_t;

  function automatic int unsigned nslice(input int unsigned w, input int unsigned d);
    return w / d;
  endfunction

endpackage

// File: rtl/beta_flag_gen_if.sv
// Operand/result handshake bundle for beta_flag_gen.
// BETA_FLAG_CARRY_EN adds the MSB carry-out signal c.
interface beta_flag_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             z;
  logic             v;
  logic             n;
`ifdef BETA_FLAG_CARRY_EN
  logic             c;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, z, v, n, c
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, z, v, n, c
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, z, v, n
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, z, v, n
  );
`endif
endinterface

// File: rtl/beta_slice_add.sv
// Combinational DIGIT-bit slice adder; also reports the carry into its top bit
// so the final slice can form the signed-overflow flag.
module beta_slice_add #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [DIGIT:0] full;

  always_comb begin
    full     = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    s        = full[DIGIT-1:0];
    cout     = full[DIGIT];
    // a^b^s at the top bit recovers the carry that entered it
    c_msb_in = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];
  end

endmodule

// File: rtl/beta_flag_gen.sv
// Multi-cycle add/subtract unit producing sum and Z/V/N flags, DIGIT bits per cycle.
// Optional macro BETA_FLAG_CARRY_EN exposes the MSB carry-out as c.
module beta_flag_gen
  import beta_flag_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  beta_flag_gen_if.slave bus
);

  localparam int unsigned NSLICE = nslice(WIDTH, DIGIT);
  localparam int unsigned CW     = $clog2(NSLICE + 1);

  if ((WIDTH % DIGIT) != 0) begin : g_cfg_err
    $error("beta_flag_gen: WIDTH must be a multiple of DIGIT");
  end

  flag_state_t      state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic             carry, zacc;
  logic [CW-1:0]    cnt;
  logic             last, accept, consume;

  logic [DIGIT-1:0] s;
  logic             cout, cmsb;

  logic [WIDTH-1:0] sum_q;
  logic             z_q, v_q, n_q;
`ifdef BETA_FLAG_CARRY_EN
  logic             c_q;
`endif

  beta_slice_add #(.DIGIT(DIGIT)) u_add (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .s        (s),
    .cout     (cout),
    .c_msb_in (cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    last          = (cnt == CW'(NSLICE - 1));
    accept        = 1'b0;
    consume       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        consume       = bus.out_ready;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // New slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0
  always_comb begin
    acc_nx = (acc >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      cnt   <= '0;
      sum_q <= '0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
      n_q   <= 1'b0;
`ifdef BETA_FLAG_CARRY_EN
      c_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      cnt   <= '0;
      zacc  <= 1'b1;
    end else if (state == BUSY) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_nx;
      carry <= cout;
      cnt   <= cnt + 1'b1;
      zacc  <= zacc & (s == '0);
      // Output registers change only here, so they hold the previous result meanwhile
      if (last) begin
        sum_q <= acc_nx;
        z_q   <= zacc & (s == '0);
        n_q   <= s[DIGIT-1];
        v_q   <= cmsb ^ cout;
`ifdef BETA_FLAG_CARRY_EN
        c_q   <= cout;
`endif
      end
    end
  end

  assign bus.sum = sum_q;
  assign bus.z   = z_q;
  assign bus.v   = v_q;
  assign bus.n   = n_q;
`ifdef BETA_FLAG_CARRY_EN
  assign bus.c   = c_q;
`endif

endmodule

// File: tb/tb_beta_flag_gen.sv
// Scoreboard bench for beta_flag_gen at WIDTH=32, DIGIT=8.
module tb_beta_flag_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  beta_flag_gen_if #(.WIDTH(32)) bus();

  beta_flag_gen #(.WIDTH(32), .DIGIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] sum;
    logic        z, v, n, c;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] sum;
    logic        z, v, n, c;
    int          hold;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on each consumed result
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", bus.sum, e.sum);
        chk("z", {31'd0, bus.z}, {31'd0, e.z});
        chk("v", {31'd0, bus.v}, {31'd0, e.v});
        chk("n", {31'd0, bus.n}, {31'd0, e.n});
`ifdef BETA_FLAG_CARRY_EN
        chk("c", {31'd0, bus.c}, {31'd0, e.c});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input vec_t t, input bit junk_in_done);
    int cyc;
    exp_t e;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = t.a;
    bus.b        = t.b;
    bus.sub      = t.sub;
    e.sum = t.sum; e.z = t.z; e.v = t.v; e.n = t.n; e.c = t.c;
    exp_q.push_back(e);
    step();
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h1234_5678;
    bus.sub      = ~t.sub;
    chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus.out_valid && cyc < 20);
    chk("latency", cyc, 32'd4);
    if (junk_in_done) bus.in_valid = 1'b1;
    for (int i = 0; i < t.hold; i++) begin
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_sum", bus.sum, t.sum);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post_hold_sum", bus.sum, t.sum);
  endtask

  initial begin
    vecs[0] = '{32'd5,        32'd5, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
    vecs[1] = '{32'd3,        32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    vecs[3] = '{32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[4] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vecs[5] = '{32'd0,        32'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7] = '{32'd1,        32'd1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", bus.sum, 32'd0);
    chk("rst_zvn", {29'd0, bus.z, bus.v, bus.n}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) do_op(vecs[i], vecs[i].hold == 5);

    // No op was started by in_valid held during DONE
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_ghost_op", {31'd0, bus.out_valid}, 32'd0);
    end

    // Abort mid-BUSY: accept, then reset two edges later
    bus.in_valid = 1'b1;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    bus.sub      = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    chk("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_sum", bus.sum, 32'd0);
    chk("abort_z", {31'd0, bus.z}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    do_op(vecs[7], 1'b0);
    repeat (2) step();
    chk("queue_empty", exp_q.size(), 32'd0);
    done = 1'b1;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: done=%0d expected 1", done);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
    end
  end

  initial begin
    wait (done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
